// File: rtl/branch_predictor_if.sv
// -----------------------------------------------------------------------------
// branch_predictor_if
// Bundles the fetch-side lookup port, the prediction response, the BRU
// resolve/update port and the redirect response of the branch predictor.
//
//   fetch_valid / fetch_pc          : fetch presents a PC for lookup
//   pred_valid / pred_pc /
//   pred_taken / pred_target        : prediction for the previous cycle's PC
//   upd_valid / upd_pc / upd_taken /
//   upd_target / upd_pred_taken /
//   upd_pred_target                 : resolved branch from the BRU
//   redirect_valid / redirect_pc    : misprediction, restart fetch here
//
// master : the pipeline side (drives fetch and update, receives responses)
// slave  : the predictor
// -----------------------------------------------------------------------------
interface branch_predictor_if;
    logic        fetch_valid;
    logic [31:0] fetch_pc;

    logic        pred_valid;
    logic [31:0] pred_pc;
    logic        pred_taken;
    logic [31:0] pred_target;

    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;

    logic        redirect_valid;
    logic [31:0] redirect_pc;

    modport master (
        output fetch_valid, fetch_pc,
        output upd_valid, upd_pc, upd_taken, upd_target,
        output upd_pred_taken, upd_pred_target,
        input  pred_valid, pred_pc, pred_taken, pred_target,
        input  redirect_valid, redirect_pc
    );

    modport slave (
        input  fetch_valid, fetch_pc,
        input  upd_valid, upd_pc, upd_taken, upd_target,
        input  upd_pred_taken, upd_pred_target,
        output pred_valid, pred_pc, pred_taken, pred_target,
        output redirect_valid, redirect_pc
    );
endinterface

// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
// Direct-mapped BTB plus a table of 2-bit saturating direction counters.
// A fetch PC is looked up in one cycle; the registered prediction appears on
// the pred_* outputs the following cycle. Resolved branches train the tables
// and raise a same-cycle redirect when the fetch-time prediction was wrong.
//
// Ports:
//   clk : single clock, all state on rising edge
//   rst : synchronous active-high reset
//   bp  : branch_predictor_if.slave (fetch, prediction, update, redirect)
//
// Parameters:
//   BTB_ENTRIES : BTB entries (power of two, 4..1024)
//   BHT_ENTRIES : direction counters (power of two, 4..4096)
//   TAG_BITS    : BTB tag width (1..30-log2(BTB_ENTRIES))
// -----------------------------------------------------------------------------
module branch_predictor #(
    parameter int BTB_ENTRIES = 64,
    parameter int BHT_ENTRIES = 256,
    parameter int TAG_BITS    = 16
) (
    input  logic               clk,
    input  logic               rst,
    branch_predictor_if.slave  bp
);

    localparam int BTB_IDX_W = $clog2(BTB_ENTRIES);
    localparam int BHT_IDX_W = $clog2(BHT_ENTRIES);
    localparam int TAG_LO    = BTB_IDX_W + 2;

    // Next value of a 2-bit saturating direction counter.
    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        case ({taken, ctr})
            3'b1_11: nxt = 2'b11;
            3'b0_00: nxt = 2'b00;
            default: nxt = taken ? (ctr + 2'd1) : (ctr - 2'd1);
        endcase
        return nxt;
    endfunction

    // Storage. Only the valid bits and counters are reset; tag/target
    // contents are meaningless while the valid bit is clear.
    logic [BTB_ENTRIES-1:0] btb_valid_r;
    logic [TAG_BITS-1:0]    btb_tag_r    [BTB_ENTRIES];
    logic [31:0]            btb_target_r [BTB_ENTRIES];
    logic [1:0]             bht_r        [BHT_ENTRIES];

    // Lookup path
    logic [BTB_IDX_W-1:0] lk_btb_idx_s;
    logic [TAG_BITS-1:0]  lk_tag_s;
    logic [BHT_IDX_W-1:0] lk_bht_idx_s;
    logic                 lk_hit_s;
    logic                 lk_taken_s;
    logic [31:0]          lk_target_s;

    // Update path
    logic [BTB_IDX_W-1:0] up_btb_idx_s;
    logic [TAG_BITS-1:0]  up_tag_s;
    logic [BHT_IDX_W-1:0] up_bht_idx_s;
    logic                 up_en_s;
    logic [31:0]          up_correct_pc_s;
    logic                 up_mispredict_s;
    logic                 redirect_s;

    // Prediction registers
    logic        pred_valid_r;
    logic [31:0] pred_pc_r;
    logic        pred_taken_r;
    logic [31:0] pred_target_r;

    // Lookup: reads pre-update table contents, so a same-cycle update to the
    // same entry is only seen by the next cycle's lookup.
    always_comb begin
        lk_btb_idx_s = bp.fetch_pc[BTB_IDX_W+1:2];
        lk_tag_s     = bp.fetch_pc[TAG_LO+TAG_BITS-1:TAG_LO];
        lk_bht_idx_s = bp.fetch_pc[BHT_IDX_W+1:2];
        lk_hit_s     = btb_valid_r[lk_btb_idx_s] && (btb_tag_r[lk_btb_idx_s] == lk_tag_s);
        lk_taken_s   = lk_hit_s && bht_r[lk_bht_idx_s][1];
        if (lk_taken_s) begin
            lk_target_s = btb_target_r[lk_btb_idx_s];
        end else begin
            lk_target_s = bp.fetch_pc + 32'd4;
        end
    end

    // Update decode and misprediction detection (redirect is same-cycle).
    always_comb begin
        up_btb_idx_s = bp.upd_pc[BTB_IDX_W+1:2];
        up_tag_s     = bp.upd_pc[TAG_LO+TAG_BITS-1:TAG_LO];
        up_bht_idx_s = bp.upd_pc[BHT_IDX_W+1:2];
        up_en_s      = bp.upd_valid && !rst;
        if (bp.upd_taken) begin
            up_correct_pc_s = bp.upd_target;
        end else begin
            up_correct_pc_s = bp.upd_pc + 32'd4;
        end
        up_mispredict_s = (bp.upd_taken != bp.upd_pred_taken) ||
                          (bp.upd_pred_target != up_correct_pc_s);
        redirect_s      = up_en_s && up_mispredict_s;
    end

    // Direction counters: reset to weakly-not-taken, trained on every update.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_r[i] <= 2'b01;
            end
        end else if (up_en_s) begin
            bht_r[up_bht_idx_s] <= ctr_next(bht_r[up_bht_idx_s], bp.upd_taken);
        end
    end

    // BTB valid bits: only taken branches allocate.
    always_ff @(posedge clk) begin
        if (rst) begin
            btb_valid_r <= {BTB_ENTRIES{1'b0}};
        end else if (up_en_s && bp.upd_taken) begin
            btb_valid_r[up_btb_idx_s] <= 1'b1;
        end
    end

    // BTB tag/target payload: overwrite the slot on a taken update.
    always_ff @(posedge clk) begin
        if (up_en_s && bp.upd_taken) begin
            btb_tag_r[up_btb_idx_s]    <= up_tag_s;
            btb_target_r[up_btb_idx_s] <= bp.upd_target;
        end
    end

    // Prediction register: a fetch concurrent with a redirect is stale and
    // is squashed.
    always_ff @(posedge clk) begin
        if (rst) begin
            pred_valid_r  <= 1'b0;
            pred_pc_r     <= 32'd0;
            pred_taken_r  <= 1'b0;
            pred_target_r <= 32'd0;
        end else begin
            pred_valid_r  <= bp.fetch_valid && !redirect_s;
            pred_pc_r     <= bp.fetch_pc;
            pred_taken_r  <= lk_taken_s;
            pred_target_r <= lk_target_s;
        end
    end

    // pred_valid is also held low throughout the reset cycle itself.
    assign bp.pred_valid     = pred_valid_r && !rst;
    assign bp.pred_pc        = pred_pc_r;
    assign bp.pred_taken     = pred_taken_r;
    assign bp.pred_target    = pred_target_r;
    assign bp.redirect_valid = redirect_s;
    assign bp.redirect_pc    = up_correct_pc_s;

endmodule
